// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ requesters onto one APB bus and
// runs each transfer through SETUP/ACCESS with wait states, PSLVERR and a stall timeout.
module apb_rr_master #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rsp_valid,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_r;
    logic [ID_W-1:0]         last_grant_r;
    logic [CNT_W-1:0]        tmo_cnt_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic                    rsp_valid_r;
    logic [ID_W-1:0]         rsp_id_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;
    logic                    rsp_timeout_r;

    logic                    grant_found_s;
    logic [ID_W-1:0]         grant_idx_s;
    logic [ID_W-1:0]         cand_idx_s;
    logic [NUM_REQ-1:0]      req_ready_s;
    logic                    timeout_hit_s;
    logic                    sel_write_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;

    // Round-robin search: first valid requester strictly after last_grant, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_idx_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx_s    = ID_W'((int'(last_grant_r) + k) % NUM_REQ);
            grant_idx_s   = (!grant_found_s && req_valid[cand_idx_s]) ? cand_idx_s : grant_idx_s;
            grant_found_s = grant_found_s | req_valid[cand_idx_s];
        end
    end

    // One-hot accept, only ever offered while idle.
    always_comb begin
        req_ready_s = '0;
        if ((state_r == ST_IDLE) && grant_found_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Mux the winning requester's fields for latching into the APB registers.
    always_comb begin
        sel_write_s = req_write[grant_idx_s];
        sel_addr_s  = req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = req_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end

    // The stall that would make the count reach TIMEOUT triggers the abort.
    always_comb begin
        if (TIMEOUT != 0) begin
            timeout_hit_s = (tmo_cnt_r == CNT_W'(TIMEOUT - 1));
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= ID_W'(NUM_REQ - 1);
            tmo_cnt_r     <= '0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= '0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tmo_cnt_r <= '0;
                    if (grant_found_s) begin
                        pwrite_r     <= sel_write_s;
                        paddr_r      <= sel_addr_s;
                        pwdata_r     <= sel_wdata_s;
                        last_grant_r <= grant_idx_s;
                        psel_r       <= 1'b1;
                        penable_r    <= 1'b0;
                        state_r      <= ST_SETUP;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_id_r      <= last_grant_r;
                        rsp_err_r     <= PSLVERR;
                        rsp_timeout_r <= 1'b0;
                        rsp_rdata_r   <= pwrite_r ? '0 : PRDATA;
                        tmo_cnt_r     <= '0;
                        state_r       <= ST_IDLE;
                    end else if (timeout_hit_s) begin
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_id_r      <= last_grant_r;
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        rsp_rdata_r   <= '0;
                        tmo_cnt_r     <= '0;
                        state_r       <= ST_IDLE;
                    end else begin
                        tmo_cnt_r     <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    tmo_cnt_r <= '0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_s;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;
    assign PSEL        = psel_r;
    assign PENABLE     = penable_r;
    assign PWRITE      = pwrite_r;
    assign PADDR       = paddr_r;
    assign PWDATA      = pwdata_r;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: vector table of single transfers plus
// hand-written contention, timeout and mid-transfer reset sequences.
module tb_apb_rr_master;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            rsp_timeout;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY = 1'b0;
    logic            PSLVERR = 1'b0;

    logic [DW-1:0]   mem [0:15];
    logic            use_mem = 1'b0;
    logic [DW-1:0]   prdata_drv = '0;

    int total = 0;
    int bad   = 0;

    apb_rr_master #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Minimal memory slave: PREADY/PSLVERR come from the bench.
    assign PRDATA = use_mem ? mem[PADDR[5:2]] : prdata_drv;
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
    end

    typedef struct {
        logic [3:0]  mask;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic        use_mem;
        logic [1:0]  exp_id;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic load_fields(input logic [1:0] id, input logic wr, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = 32'hBAD0_0000 | 32'(i);
            req_wdata[i*DW +: DW] = 32'h5EED_0000 | 32'(i);
        end
        req_write     = {NR{~wr}};
        req_write[id] = wr;
        req_addr[id*AW +: AW]  = a;
        req_wdata[id*DW +: DW] = d;
    endtask

    // One complete transfer, checked cycle by cycle from request to the cycle after the response.
    task automatic xfer(input vec_t v);
        logic [3:0] onehot;
        onehot = 4'b0001 << v.exp_id;
        load_fields(v.exp_id, v.write, v.addr, v.wdata);
        req_valid  = v.mask;
        PREADY     = (v.waits == 0);
        PSLVERR    = v.slverr;
        prdata_drv = v.prdata;
        use_mem    = v.use_mem;
        #1;
        check("grant", 64'(req_ready), 64'(onehot));
        tick();
        req_valid = v.mask & ~onehot;
        #1;
        check("no_accept_busy", 64'(req_ready), 64'd0);
        check("setup_ctrl", 64'({PSEL, PENABLE}), 64'd2);
        check("setup_addr", 64'(PADDR), 64'(v.addr));
        check("setup_write", 64'(PWRITE), 64'(v.write));
        if (v.write) check("setup_wdata", 64'(PWDATA), 64'(v.wdata));
        tick();
        req_valid = '0;
        PREADY    = (v.waits == 0);
        check("access_ctrl", 64'({PSEL, PENABLE}), 64'd3);
        check("access_norsp", 64'(rsp_valid), 64'd0);
        for (int w = 0; w < v.waits; w++) begin
            tick();
            PREADY = (w == v.waits - 1);
            check("wait_ctrl", 64'({PSEL, PENABLE}), 64'd3);
            check("wait_addr", 64'(PADDR), 64'(v.addr));
            check("wait_norsp", 64'(rsp_valid), 64'd0);
        end
        tick();
        PREADY = 1'b0;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(v.exp_id));
        check("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        check("rsp_err", 64'(rsp_err), 64'(v.exp_err));
        check("rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("done_ctrl", 64'({PSEL, PENABLE}), 64'd0);
        check("done_addr", 64'(PADDR), 64'(v.addr));
        tick();
        check("rsp_pulse", 64'(rsp_valid), 64'd0);
        check("rsp_hold", 64'(rsp_rdata), 64'(v.exp_rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts [0:3];
        vec_t v;

        //              mask     wr    addr          wdata          wt slv  prdata        mem   id     exp_rdata     err
        vecs[0] = '{4'b0001, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 0, 1'b0, 32'h0,        1'b0, 2'd0, 32'h0,        1'b0};
        vecs[1] = '{4'b0001, 1'b0, 32'h0000_0010, 32'h0,         0, 1'b0, 32'h0,        1'b1, 2'd0, 32'hA5A5_A5A5, 1'b0};
        vecs[2] = '{4'b0100, 1'b0, 32'h0000_0020, 32'h0,         2, 1'b0, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{4'b0110, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 0, 1'b1, 32'h0,        1'b0, 2'd1, 32'h0,        1'b1};
        vecs[4] = '{4'b1001, 1'b0, 32'h0000_0034, 32'h0,         1, 1'b0, 32'h1234_5678, 1'b0, 2'd3, 32'h1234_5678, 1'b0};
        vecs[5] = '{4'b1111, 1'b1, 32'h0000_0038, 32'h0F0F_0F0F, 0, 1'b0, 32'h0,        1'b0, 2'd0, 32'h0,        1'b0};
        vecs[6] = '{4'b1100, 1'b0, 32'h0000_003C, 32'h0,         0, 1'b1, 32'hCAFE_F00D, 1'b0, 2'd2, 32'hCAFE_F00D, 1'b1};
        vecs[7] = '{4'b1011, 1'b1, 32'h0000_0004, 32'h7777_1111, 3, 1'b0, 32'h0,        1'b0, 2'd3, 32'h0,        1'b0};

        // Reset state
        #12;
        check("rst_ctrl", 64'({PSEL, PENABLE, PWRITE}), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_id}), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_ready_idle", 64'(req_ready), 64'd0);
        req_valid = 4'b1111;
        #1;
        check("rst_first_prio", 64'(req_ready), 64'd1);
        req_valid = '0;
        tick();
        PRESETn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) xfer(vecs[i]);

        // Continuous contention after a fresh reset
        PRESETn = 1'b0;
        #2;
        PRESETn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) accepts[i] = 0;
        load_fields(2'd0, 1'b0, 32'h0000_0100, 32'h0);
        req_write  = '0;
        use_mem    = 1'b0;
        prdata_drv = 32'h1111_0000;
        PSLVERR    = 1'b0;
        PREADY     = 1'b1;
        req_valid  = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            #1;
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << (t % 4)));
            if (t < 4) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) accepts[i]++;
            end
            tick();
            check("rr_busy_setup", 64'(req_ready), 64'd0);
            tick();
            check("rr_busy_access", 64'(req_ready), 64'd0);
            tick();
            check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            check("rr_rsp_id", 64'(rsp_id), 64'(t % 4));
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) check("rr_once_each", 64'(accepts[i]), 64'd1);
        tick();

        // Timeout: PREADY stuck low, requester 1
        load_fields(2'd1, 1'b0, 32'h0000_0040, 32'h0);
        prdata_drv = 32'hFFFF_FFFF;
        PREADY     = 1'b0;
        req_valid  = 4'b0010;
        #1;
        check("tmo_grant", 64'(req_ready), 64'd2);
        tick();
        req_valid = '0;
        tick();
        check("tmo_access", 64'({PSEL, PENABLE}), 64'd3);
        for (int c = 3; c <= 17; c++) begin
            tick();
            check("tmo_stall_ctrl", 64'({PSEL, PENABLE}), 64'd3);
            check("tmo_stall_norsp", 64'(rsp_valid), 64'd0);
        end
        tick();
        check("tmo_ctrl", 64'({PSEL, PENABLE}), 64'd0);
        check("tmo_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd7);
        check("tmo_id", 64'(rsp_id), 64'd1);
        check("tmo_rdata", 64'(rsp_rdata), 64'd0);
        tick();
        check("tmo_pulse", 64'(rsp_valid), 64'd0);
        check("tmo_hold", 64'(rsp_timeout), 64'd1);
        v = '{4'b0100, 1'b1, 32'h0000_0008, 32'h2468_ACE0, 0, 1'b0, 32'h0, 1'b0, 2'd2, 32'h0, 1'b0};
        xfer(v);

        // Reset during ACCESS
        load_fields(2'd1, 1'b0, 32'h0000_000C, 32'h0);
        PREADY    = 1'b0;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        check("mid_access", 64'({PSEL, PENABLE}), 64'd3);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_ctrl", 64'({PSEL, PENABLE}), 64'd0);
        check("mid_rst_norsp", 64'(rsp_valid), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_rst_hold", 64'({rsp_valid, PSEL}), 64'd0);
        end
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        v = '{4'b1010, 1'b0, 32'h0000_0014, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 1'b0, 2'd1, 32'h0BAD_CAFE, 1'b0};
        xfer(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
